// File: rtl/op_f_pkg.sv
// Shared types and default truth tables for the op_f 4-input classifier.
package op_f_pkg;
  typedef logic [3:0] code_t;

  localparam logic [15:0] PRIME_MASK = 16'h28AC;
  localparam logic [15:0] DIV3_MASK  = 16'h9249;
endpackage

// File: rtl/op_f_decode.sv
// Combinational truth-table lookup: one mask bit per 4-bit code.
module op_f_decode
  import op_f_pkg::*;
#(
  parameter logic [15:0] Y_MASK = PRIME_MASK,
  parameter logic [15:0] Z_MASK = DIV3_MASK
) (
  input  code_t n,
  output logic  y_c,
  output logic  z_c
);
  assign y_c = Y_MASK[n];
  assign z_c = Z_MASK[n];
endmodule

// File: rtl/op_f_unit.sv
// Registered classifier: y/z flags one cycle after a valid {a,b,c,d} sample.
// Optional saturating hit counters are built when OP_F_COUNT_EN is defined.
module op_f_unit
  import op_f_pkg::*;
#(
  parameter logic [15:0] Y_MASK = PRIME_MASK,
  parameter logic [15:0] Z_MASK = DIV3_MASK,
  parameter int          CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             d,
  output logic             y,
  output logic             z,
`ifdef OP_F_COUNT_EN
  output logic [CNT_W-1:0] y_count,
  output logic [CNT_W-1:0] z_count,
`endif
  output logic             out_valid
);
  code_t n;
  logic  y_c, z_c;
  logic  y_d, y_q, z_d, z_q, out_valid_d, out_valid_q;

  assign n = {a, b, c, d};

  op_f_decode #(.Y_MASK(Y_MASK), .Z_MASK(Z_MASK)) u_decode (
    .n  (n),
    .y_c(y_c),
    .z_c(z_c)
  );

  // Flags hold across invalid cycles; only out_valid tracks every cycle.
  always_comb begin
    y_d         = y_q;
    z_d         = z_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      y_d = y_c;
      z_d = z_c;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q         <= 1'b0;
      z_q         <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      y_q         <= y_d;
      z_q         <= z_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign y         = y_q;
  assign z         = z_q;
  assign out_valid = out_valid_q;

`ifdef OP_F_COUNT_EN
  logic [CNT_W-1:0] y_cnt_d, y_cnt_q, z_cnt_d, z_cnt_q;

  // Counters stick at all-ones rather than wrapping.
  always_comb begin
    y_cnt_d = y_cnt_q;
    z_cnt_d = z_cnt_q;
    if (in_valid && y_c && (y_cnt_q != {CNT_W{1'b1}})) y_cnt_d = y_cnt_q + CNT_W'(1);
    if (in_valid && z_c && (z_cnt_q != {CNT_W{1'b1}})) z_cnt_d = z_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_cnt_q <= '0;
      z_cnt_q <= '0;
    end else begin
      y_cnt_q <= y_cnt_d;
      z_cnt_q <= z_cnt_d;
    end
  end

  assign y_count = y_cnt_q;
  assign z_count = z_cnt_q;
`endif
endmodule

// File: tb/tb_op_f_unit.sv
// Bench for op_f_unit: reset, exhaustive sweep, hold, random traffic, async reset,
// custom masks and (with OP_F_COUNT_EN) counter saturation, against an arithmetic model.
module tb_op_f_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0;
  logic y, z, out_valid;
  logic cy, cz, cov;
`ifdef OP_F_COUNT_EN
  logic [7:0] y_count, z_count;
  logic [7:0] cy_count, cz_count;
  logic       sy, sz, sov;
  logic [1:0] sy_count, sz_count;
`endif

  int cmp = 0;
  int mis = 0;

  bit ey, ez, ev;
  int ecy, ecz;

  always #5 clk = ~clk;

  op_f_unit u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .c(c), .d(d),
    .y(y), .z(z),
`ifdef OP_F_COUNT_EN
    .y_count(y_count), .z_count(z_count),
`endif
    .out_valid(out_valid)
  );

  op_f_unit #(.Y_MASK(16'h0001), .Z_MASK(16'h8000)) u_cst (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .c(c), .d(d),
    .y(cy), .z(cz),
`ifdef OP_F_COUNT_EN
    .y_count(cy_count), .z_count(cz_count),
`endif
    .out_valid(cov)
  );

`ifdef OP_F_COUNT_EN
  op_f_unit #(.CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .c(c), .d(d),
    .y(sy), .z(sz), .y_count(sy_count), .z_count(sz_count), .out_valid(sov)
  );
`endif

  function automatic bit is_prime(int n);
    if (n < 2) return 1'b0;
    for (int k = 2; k * k <= n; k++) if (n % k == 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp++;
    assert (obs === exp) else begin
      mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    ey = 0; ez = 0; ev = 0; ecy = 0; ecz = 0;
  endtask

  task automatic check_main(input string tag);
    chk({tag, ".y"}, y, ey);
    chk({tag, ".z"}, z, ez);
    chk({tag, ".ov"}, out_valid, ev);
`ifdef OP_F_COUNT_EN
    chk({tag, ".ycnt"}, y_count, ecy);
    chk({tag, ".zcnt"}, z_count, ecz);
`endif
  endtask

  // Apply one sample, clock it in, update the model, and compare.
  task automatic drive(input bit v, input int n, input string tag);
    in_valid = v;
    {a, b, c, d} = 4'(n);
    @(posedge clk);
    #1;
    ev = v;
    if (v) begin
      ey = is_prime(n);
      ez = (n % 3 == 0);
      if (ey && ecy < 255) ecy++;
      if (ez && ecz < 255) ecz++;
    end
    check_main(tag);
  endtask

  initial begin
    model_reset();
    // Reset with random inputs toggling
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      {a, b, c, d} = 4'($urandom_range(0, 15));
      @(posedge clk);
      #1;
    end
    check_main("reset");
    chk("reset.cst_y", cy, 1'b0);
    chk("reset.cst_ov", cov, 1'b0);
    in_valid = 1'b0;
    rst = 1'b0;

    // Exhaustive sweep, custom-mask instance alongside
    for (int n = 0; n < 16; n++) begin
      drive(1'b1, n, $sformatf("sweep%0d", n));
      chk($sformatf("cst%0d.y", n), cy, (n == 0));
      chk($sformatf("cst%0d.z", n), cz, (n == 15));
    end

    // Hold across an invalid cycle
    drive(1'b1, 3, "hold_set");
    drive(1'b0, 4, "hold");
    chk("hold.y_lit", y, 1'b1);
    chk("hold.z_lit", z, 1'b1);
    chk("hold.ov_lit", out_valid, 1'b0);

    // Random traffic
    for (int i = 0; i < 300; i++)
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 15), $sformatf("rand%0d", i));

    // Async reset mid-cycle
    drive(1'b1, 3, "pre_arst");
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("arst.y", y, 1'b0);
    chk("arst.z", z, 1'b0);
    chk("arst.ov", out_valid, 1'b0);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_main("arst_hold");

`ifdef OP_F_COUNT_EN
    chk("sat.init_y", sy_count, 2'd0);
    for (int i = 0; i < 5; i++) drive(1'b1, 3, $sformatf("sat%0d", i));
    chk("sat.ycnt", sy_count, 2'd3);
    chk("sat.zcnt", sz_count, 2'd3);
`endif

    in_valid = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
    $finish;
  end
endmodule
